// File: rtl/riscv_div.sv
// riscv_div: RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
// Latency: done in the cycle after accept+WORD_LENGTH edges; div-by-zero/overflow done in the cycle after accept.
// Backpressure: start is sampled only in IDLE; upstream must stall while busy. flush kills any op in flight.
// Ports: clk, rst_n (sync, active-low); start, div_op[1:0], op1, op2, flush in;
//        busy (state != IDLE), done (1-cycle pulse), result (held until next completion) out.
module riscv_div #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             div_op,
  input  logic [WORD_LENGTH-1:0] op1,
  input  logic [WORD_LENGTH-1:0] op2,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] result
);

  localparam int CW = $clog2(WORD_LENGTH);
  localparam logic [WORD_LENGTH-1:0] MIN_NEG = {1'b1, {(WORD_LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  // quot_q starts as the dividend magnitude; quotient bits shift in from the LSB
  logic [WORD_LENGTH-1:0] quot_q, quot_d;
  logic [WORD_LENGTH-1:0] rem_q, rem_d;
  logic [WORD_LENGTH-1:0] divisor_q, divisor_d;
  logic                   is_rem_q, is_rem_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [WORD_LENGTH-1:0] result_q, result_d;

  logic                   signed_op;
  logic [WORD_LENGTH-1:0] mag1, mag2;
  logic [WORD_LENGTH:0]   rem_sh;
  logic [WORD_LENGTH:0]   trial;
  logic [WORD_LENGTH-1:0] quot_nxt, rem_nxt, res_fin;

  assign signed_op = ~div_op[0];
  assign mag1      = (signed_op && op1[WORD_LENGTH-1]) ? -op1 : op1;
  assign mag2      = (signed_op && op2[WORD_LENGTH-1]) ? -op2 : op2;

  // rem < divisor always holds, so the shifted remainder is below 2*divisor and
  // WORD_LENGTH+1 bits are enough for trial; its MSB is the borrow.
  assign rem_sh   = {rem_q, quot_q[WORD_LENGTH-1]};
  assign trial    = rem_sh - {1'b0, divisor_q};
  assign quot_nxt = {quot_q[WORD_LENGTH-2:0], ~trial[WORD_LENGTH]};
  assign rem_nxt  = trial[WORD_LENGTH] ? rem_sh[WORD_LENGTH-1:0] : trial[WORD_LENGTH-1:0];
  // Final sign fix-up uses this iteration's values so result lands on the edge that enters DONE
  assign res_fin  = is_rem_q ? (neg_rem_q ? -rem_nxt  : rem_nxt)
                             : (neg_quo_q ? -quot_nxt : quot_nxt);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d = div_op[1];
          if (op2 == '0) begin
            result_d = div_op[1] ? op1 : '1;
            state_d  = S_DONE;
          end else if (signed_op && (op1 == MIN_NEG) && (op2 == '1)) begin
            result_d = div_op[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            quot_d    = mag1;
            divisor_d = mag2;
            rem_d     = '0;
            count_d   = '0;
            neg_quo_d = signed_op & (op1[WORD_LENGTH-1] ^ op2[WORD_LENGTH-1]);
            neg_rem_d = signed_op & op1[WORD_LENGTH-1];
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        quot_d  = quot_nxt;
        rem_d   = rem_nxt;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WORD_LENGTH - 1)) begin
          result_d = res_fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // flush wins over everything: abandon the op and keep the previous result
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  // A flush arriving in the DONE cycle itself must still hide the completion,
  // so the registered DONE state is masked by the kill.
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;

endmodule
